// File: rtl/hdlc_pkg.sv
// hdlc_pkg
// Shared definitions for blocks that talk to the Hdlc controller register
// port: register addresses, bit positions inside Rx_SC, and the state
// enumeration used by the receive drain FSM.
package hdlc_pkg;

   // Hdlc register addresses
   localparam logic [2:0] RX_SC_ADDR   = 3'd2;
   localparam logic [2:0] RX_BUFF_ADDR = 3'd3;
   localparam logic [2:0] RX_LEN_ADDR  = 3'd4;

   // Bit positions inside Rx_SC
   localparam int RX_DROP_BIT = 1;
   localparam int RX_OVF_BIT  = 4;

   // Receive drain FSM states
   typedef enum logic [3:0] {
      IDLE,
      RD_SC,
      CAP_SC,
      RD_LEN,
      CAP_LEN,
      RD_BYTE,
      CAP_BYTE,
      HOLD,
      DROP,
      DONE
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Counter that steps by one on each cycle 'inc' is high and sticks at
// all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - count enable for this cycle
//   count - current count value
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up, holding at all-ones once reached
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hdlc_rx_drain.sv
// hdlc_rx_drain
// Drains received frames out of the Hdlc controller. When Hdlc flags a
// frame it reads Rx_SC and Rx_Len, then pulls the frame out of Rx_Buff one
// byte at a time and presents each byte on a valid/ready stream. Empty
// frames are discarded with an Rx_Drop write; overflowed frames are
// delivered with m_err set.
// Ports:
//   Clk, Rst          - clock and synchronous active-high reset
//   Rx_Ready          - Hdlc frame-available flag
//   Address, ReadEnable, WriteEnable, DataIn, DataOut - Hdlc register port
//   m_data, m_valid, m_ready, m_last, m_err           - byte stream
//   frames_ok, frames_dropped                         - saturating counters
module hdlc_rx_drain
   import hdlc_pkg::*;
#(
   parameter int MAX_LEN = 128,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Rx_Ready,
   output logic [2:0]       Address,
   output logic             ReadEnable,
   output logic             WriteEnable,
   output logic [7:0]       DataIn,
   input  logic [7:0]       DataOut,
   output logic [7:0]       m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             m_err,
   output logic [CNT_W-1:0] frames_ok,
   output logic [CNT_W-1:0] frames_dropped
);

   state_t     state, state_nxt;
   logic       rx_ready_q;
   logic [7:0] remaining, remaining_nxt;
   logic       ovf, ovf_nxt;
   logic [7:0] len_clamped;
   logic [2:0] address_nxt;
   logic       read_en_nxt, write_en_nxt, m_valid_nxt;
   logic       m_last_nxt, m_err_nxt;
   logic [7:0] data_in_nxt, m_data_nxt;
   logic       ok_inc, drop_inc;

   // Next-state logic. Port outputs are registered from the next state so
   // that each strobe is high exactly for the cycle spent in its state.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      ovf_nxt       = ovf;
      m_data_nxt    = m_data;
      m_last_nxt    = m_last;
      m_err_nxt     = m_err;
      ok_inc        = 1'b0;
      drop_inc      = 1'b0;
      len_clamped   = (DataOut > 8'(MAX_LEN)) ? 8'(MAX_LEN) : DataOut;

      case (state)
         IDLE:     if (rx_ready_q) state_nxt = RD_SC;
         RD_SC:    state_nxt = CAP_SC;
         CAP_SC: begin
            ovf_nxt   = DataOut[RX_OVF_BIT];
            state_nxt = RD_LEN;
         end
         RD_LEN:   state_nxt = CAP_LEN;
         CAP_LEN: begin
            remaining_nxt = len_clamped;
            state_nxt     = (len_clamped == 8'd0) ? DROP : RD_BYTE;
         end
         RD_BYTE:  state_nxt = CAP_BYTE;
         CAP_BYTE: begin
            m_data_nxt    = DataOut;
            remaining_nxt = remaining - 8'd1;
            m_last_nxt    = (remaining == 8'd1);
            m_err_nxt     = ovf;
            state_nxt     = HOLD;
         end
         HOLD: begin
            if (m_ready) begin
               m_last_nxt = 1'b0;
               if (remaining == 8'd0) begin
                  ok_inc    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = RD_BYTE;
               end
            end
         end
         DROP: begin
            drop_inc  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            // Rx_Ready must fall before a new frame is looked at, otherwise
            // the frame just drained would be read a second time.
            if (!rx_ready_q) begin
               m_err_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default:  state_nxt = IDLE;
      endcase

      read_en_nxt  = (state_nxt == RD_SC) || (state_nxt == RD_LEN) ||
                     (state_nxt == RD_BYTE);
      write_en_nxt = (state_nxt == DROP);
      m_valid_nxt  = (state_nxt == HOLD);
      data_in_nxt  = (state_nxt == DROP) ? 8'(1 << RX_DROP_BIT) : 8'h00;
      case (state_nxt)
         RD_SC, DROP: address_nxt = RX_SC_ADDR;
         RD_LEN:      address_nxt = RX_LEN_ADDR;
         RD_BYTE:     address_nxt = RX_BUFF_ADDR;
         default:     address_nxt = 3'd0;
      endcase
   end

   // State, datapath and registered port outputs
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= IDLE;
         rx_ready_q  <= 1'b0;
         remaining   <= 8'd0;
         ovf         <= 1'b0;
         Address     <= 3'd0;
         ReadEnable  <= 1'b0;
         WriteEnable <= 1'b0;
         DataIn      <= 8'h00;
         m_data      <= 8'h00;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         m_err       <= 1'b0;
      end else begin
         state       <= state_nxt;
         rx_ready_q  <= Rx_Ready;
         remaining   <= remaining_nxt;
         ovf         <= ovf_nxt;
         Address     <= address_nxt;
         ReadEnable  <= read_en_nxt;
         WriteEnable <= write_en_nxt;
         DataIn      <= data_in_nxt;
         m_data      <= m_data_nxt;
         m_valid     <= m_valid_nxt;
         m_last      <= m_last_nxt;
         m_err       <= m_err_nxt;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) ok_counter (
      .clk   (Clk),
      .rst   (Rst),
      .inc   (ok_inc),
      .count (frames_ok)
   );

   sat_counter #(.CNT_W(CNT_W)) drop_counter (
      .clk   (Clk),
      .rst   (Rst),
      .inc   (drop_inc),
      .count (frames_dropped)
   );

endmodule

// File: doc/hdlc_rx_drain.md
# hdlc_rx_drain

Host-side receive drain for the `Hdlc` controller. It sits directly downstream of `Hdlc`'s register port and watches `Rx_Ready`. When a frame is ready, it reads the Rx status and length registers and pulls the frame out of the Rx buffer one byte at a time. Frames are delivered as a valid/ready byte stream with an end-of-frame marker. Empty or overflowed frames are dropped or flagged, and good and dropped frames are counted.

## Interface
Parameters:
- `MAX_LEN`, 128: Rx buffer depth in bytes. Larger length readings are clamped to this.
- `CNT_W`, 16: width of the saturating frame counters.

Ports:
- `Clk`  in  1  single clock. Reset is synchronous and active-high.
- `Rst`  in  1  synchronous, active-high reset.
- `Rx_Ready`  in  1  `Hdlc` frame-available flag.
- `Address`  out  3  `Hdlc` register address.
- `ReadEnable`  out  1  `Hdlc` read strobe.
- `WriteEnable`  out  1  `Hdlc` write strobe.
- `DataIn`  out  8  write data to `Hdlc`.
- `DataOut`  in  8  read data from `Hdlc`. Valid one cycle after `ReadEnable`.
- `m_data`  out  8  stream byte.
- `m_valid`  out  1  stream byte valid.
- `m_ready`  in  1  downstream accept.
- `m_last`  out  1  final byte of the frame. Qualified by `m_valid`.
- `m_err`  out  1  frame overflowed. Held for the whole frame.
- `frames_ok`  out  `CNT_W`  frames fully delivered.
- `frames_dropped`  out  `CNT_W`  frames dropped.

## Operation
Hdlc register map:
- 2 = `Rx_SC`. Bit 1 = `Rx_Drop` (write-1). Bit 4 = `Rx_Overflow`.
- 3 = `Rx_Buff`.
- 4 = `Rx_Len`.

FSM states: IDLE → RD_SC → CAP_SC → RD_LEN → CAP_LEN → {RD_BYTE → CAP_BYTE → HOLD}* → DONE, with a branch to DROP.
- **IDLE:** leave when `Rx_Ready`=1.
- **RD_SC:** `Address`=2, `ReadEnable`=1 for one cycle.
- **CAP_SC:** capture `DataOut[4]` into `ovf`.
- **RD_LEN / CAP_LEN:** read address 4.
  - Set `remaining = min(DataOut, MAX_LEN)`, 8-bit.
  - If `remaining`=0, go to DROP.
- **RD_BYTE:** `Address`=3, `ReadEnable`=1 for one cycle.
- **CAP_BYTE:** latch `DataOut` into `m_data`. Decrement `remaining`. Go to HOLD.
- **HOLD:**
  - `m_valid`=1, `m_last` = (`remaining`==0), `m_err`=`ovf`.
  - Stay until `m_ready`=1.
  - On acceptance, go to DONE if `remaining` was 0, otherwise RD_BYTE.
- **DROP:**
  - Issue one write cycle: `Address`=2, `DataIn`=8'h02, `WriteEnable`=1.
  - Increment `frames_dropped`, then go to DONE.
- **DONE:**
  - If arriving from HOLD, `frames_ok` increments on the HOLD→DONE edge.
  - Wait for `Rx_Ready`=0, then go to IDLE. This guard prevents re-reading the same frame.

Further rules:
- An overflowed frame with nonzero length is delivered in full with `m_err`=1, and it is counted in `frames_ok`.
- Counters saturate at all-ones.
- `ReadEnable` and `WriteEnable` are never high in the same cycle.
- The read strobe is never issued while in HOLD.
- `m_data`, `m_last` and `m_err` stay stable while `m_valid`=1 and `m_ready`=0.

## Timing
- **Reset values:**
  - All strobes, `m_valid`, `m_last` and `m_err` = 0.
  - `Address`=0, `DataIn`=0, `m_data`=0, counters=0.
  - State = IDLE.
- **Reset mid-frame:**
  - Output drops the same cycle `Rst` is sampled. No `m_last` is ever produced for the aborted frame.
  - After reset, the frame still held in `Hdlc` is re-read from RD_SC. Its bytes are re-delivered from byte 0.
- **Latency:**
  - `Rx_Ready` rising to the first `m_valid` is 7 cycles, with the `Rx_Ready` sampling edge as cycle 0.
  - Steady state is 3 cycles per byte when `m_ready`=1.
- Stream back-pressure is unbounded. No timeout.
- `Rx_Ready` deasserting mid-frame is ignored until DONE.
- All outputs are registered.

## Structure
- `hdlc_pkg` holds:
  - address constants `RX_SC_ADDR`=2, `RX_BUFF_ADDR`=3, `RX_LEN_ADDR`=4;
  - bit indices `RX_DROP_BIT`=1, `RX_OVF_BIT`=4;
  - the FSM state enum.
- Sub-module `sat_counter`, parameterised by `CNT_W`, instantiated twice for the counters.
- Everything else is a single module.

## Test plan
- **3-byte frame** 8'hA1, 8'hB2, 8'hC3 (`Rx_Len`=3, SC=0), with `m_ready`=1:
  - three beats; `m_last` only on C3; `m_err`=0;
  - `frames_ok`=1; first `m_valid` 7 cycles after `Rx_Ready`.
- **Back-pressure:** same frame with `m_ready` low for 10 cycles on byte 2.
  - B2 is held stable and no extra `ReadEnable` is issued.
- **Zero-length frame:** `Rx_Len`=0.
  - Exactly one write, `Address`=2, `DataIn`=8'h02.
  - No `m_valid`; `frames_dropped`=1.
- **Overflow frame:** SC=8'h10, `Rx_Len`=128.
  - 128 beats, all with `m_err`=1; `m_last` on beat 128.
  - Oversized length: `Rx_Len`=200 yields exactly 128 beats.
- **Reset mid-frame:** `Rst` after byte 2 of a 5-byte frame with `Rx_Ready` held high.
  - Outputs clear; `frames_ok`=0.
  - Re-delivery starts at byte 0 and completes with 5 beats.
- **Held `Rx_Ready`:** `Rx_Ready` stays high 20 cycles after the frame completes.
  - No re-read occurs; FSM stays in DONE; IDLE is reached one cycle after `Rx_Ready` falls.
